// File: rtl/rpc_method_target.sv
// Multi-channel method-call target: round-robin intake, call FIFO,
// single executor with a registered valid/ready response channel.
module rpc_method_target #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 4,
    parameter int INC_AMT    = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_CH-1:0]              req_valid,
    output logic [NUM_CH-1:0]              req_ready,
    input  logic [NUM_CH*ID_WIDTH-1:0]     req_id,
    input  logic [NUM_CH*2-1:0]            req_method,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   req_arg,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [2:0]                     rsp_ch,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic [15:0]                    calls_done
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(INC_AMT);

    typedef struct packed {
        logic [2:0]            ch;
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            method;
        logic [DATA_WIDTH-1:0] arg;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wdata;
    entry_t          head;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_next;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            gnt_found;
    int              gnt_i;
    int              idx;
    logic            push;
    logic            pop;
    logic [DATA_WIDTH-1:0] exec_data;
    logic            exec_err;

    // First valid channel at or above rr_ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_i     = 0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_i     = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = reset_n && gnt_found && (gnt_i == i) &&
                           (count < CW'(DEPTH));
        end
    end

    assign push    = |req_ready;
    assign pop     = (count != '0) && (!rsp_valid || rsp_ready);
    assign rr_next = (gnt_i == NUM_CH - 1) ? '0 : PW'(gnt_i + 1);
    assign head    = mem[rd_ptr];

    always_comb begin
        wdata        = '0;
        wdata.ch     = 3'(gnt_i);
        wdata.id     = req_id[gnt_i*ID_WIDTH +: ID_WIDTH];
        wdata.method = req_method[gnt_i*2 +: 2];
        wdata.arg    = req_arg[gnt_i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        exec_data = '0;
        exec_err  = 1'b0;
        unique case (head.method)
            2'd0: exec_data = head.arg + INC;
            2'd1: exec_data = head.arg - INC;
            2'd2: exec_data = DATA_WIDTH'(calls_done);
            2'd3: exec_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rsp_valid  <= 1'b0;
            rsp_ch     <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            calls_done <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= rr_next;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                rsp_valid <= 1'b1;
                rsp_ch    <= head.ch;
                rsp_id    <= head.id;
                rsp_data  <= exec_data;
                rsp_err   <= exec_err;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_valid && rsp_ready && calls_done != 16'hFFFF)
                calls_done <= calls_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_rpc_method_target.sv
// Directed self-checking bench for rpc_method_target.
module tb_rpc_method_target;

    localparam int DW = 32;
    localparam int IW = 8;
    localparam int NC = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NC-1:0]     req_valid;
    logic [NC-1:0]     req_ready;
    logic [NC*IW-1:0]  req_id;
    logic [NC*2-1:0]   req_method;
    logic [NC*DW-1:0]  req_arg;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_ch;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic [15:0]       calls_done;

    logic              v3, r3, rv3, rr3, re3;
    logic [IW-1:0]     id3, rid3;
    logic [1:0]        m3;
    logic [DW-1:0]     a3, rd3;
    logic [2:0]        rch3;
    logic [15:0]       cd3;

    always #5 clock = ~clock;

    rpc_method_target #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_CH(NC), .DEPTH(4), .INC_AMT(1)
    ) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_method(req_method), .req_arg(req_arg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .calls_done(calls_done)
    );

    rpc_method_target #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_CH(1), .DEPTH(2), .INC_AMT(3)
    ) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(v3), .req_ready(r3), .req_id(id3),
        .req_method(m3), .req_arg(a3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_ch(rch3),
        .rsp_id(rid3), .rsp_data(rd3), .rsp_err(re3),
        .calls_done(cd3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int ch;
        int id;
    } ev_t;

    ev_t acc_q[$];
    ev_t rsp_q[$];

    // Inputs change only just after posedge, so negedge sees the handshake
    always @(negedge clock) begin
        for (int c = 0; c < NC; c++)
            if (req_valid[c] && req_ready[c])
                acc_q.push_back('{c, int'(req_id[c*IW +: IW])});
        if (rsp_valid && rsp_ready)
            rsp_q.push_back('{int'(rsp_ch), int'(rsp_id)});
    end

    task automatic set_req(input int c, input int id, input int m,
                           input logic [DW-1:0] a);
        req_valid[c]         = 1'b1;
        req_id[c*IW +: IW]   = IW'(id);
        req_method[c*2 +: 2] = 2'(m);
        req_arg[c*DW +: DW]  = a;
    endtask

    task automatic send(input int c, input int id, input int m,
                        input logic [DW-1:0] a, input int maxc,
                        output bit ok);
        set_req(c, id, m, a);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (req_ready[c]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clock);
            #1;
            req_valid[c] = 1'b0;
        end
    endtask

    task automatic get_rsp(output logic [2:0] ch, output logic [IW-1:0] id,
                           output logic [DW-1:0] d, output logic e);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", 0, 1);
        ch = rsp_ch;
        id = rsp_id;
        d  = rsp_data;
        e  = rsp_err;
        @(posedge clock);
        #1;
    endtask

    task automatic do_call(input int c, input int id, input int m,
                           input logic [DW-1:0] a,
                           output logic [2:0] ch, output logic [IW-1:0] rid,
                           output logic [DW-1:0] d, output logic e);
        bit ok;
        send(c, id, m, a, 30, ok);
        if (!ok) chk("acc_timeout", 0, 1);
        get_rsp(ch, rid, d, e);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no_end expected finish");
        $fatal(1);
    end

    logic [2:0]    o_ch;
    logic [IW-1:0] o_id;
    logic [DW-1:0] o_d;
    logic          o_e;
    bit            ok;
    int            nacc;
    int            id0, id1;
    logic [NC-1:0] acc;
    int            exp_ch[4] = '{0, 1, 0, 1};
    int            exp_id[4] = '{10, 20, 11, 21};

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_id     = '0;
        req_method = '0;
        req_arg    = '0;
        rsp_ready  = 1'b0;
        v3 = 1'b0; id3 = '0; m3 = '0; a3 = '0; rr3 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        req_valid = 2'b01;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_calls_done", calls_done, 0);
        req_valid = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // basic increment and latency
        rsp_ready = 1'b1;
        send(0, 5, 0, 41, 10, ok);
        chk("t1_acc", ok, 1);
        chk("t1_lat_early", rsp_valid, 0);
        @(posedge clock);
        #1;
        chk("t1_valid", rsp_valid, 1);
        chk("t1_ch", rsp_ch, 0);
        chk("t1_id", rsp_id, 5);
        chk("t1_data", rsp_data, 42);
        chk("t1_err", rsp_err, 0);
        @(posedge clock);
        #1;
        chk("t1_calls_done", calls_done, 1);
        chk("t1_drop", rsp_valid, 0);

        // wrap-around arithmetic
        do_call(0, 1, 0, 32'hFFFF_FFFF, o_ch, o_id, o_d, o_e);
        chk("t2_inc_wrap", o_d, 32'h0);
        do_call(0, 2, 1, 32'h0, o_ch, o_id, o_d, o_e);
        chk("t2_dec_wrap", o_d, 32'hFFFF_FFFF);
        rr3 = 1'b1;
        v3 = 1'b1; id3 = 8'd7; m3 = 2'd0; a3 = 32'hFFFF_FFFE;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (r3) begin ok = 1'b1; break; end
        end
        chk("t2_inc3_acc", ok, 1);
        @(posedge clock);
        #1;
        v3 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rv3) begin ok = 1'b1; break; end
        end
        chk("t2_inc3_valid", ok, 1);
        chk("t2_inc3_data", rd3, 32'h1);
        chk("t2_inc3_ch", rch3, 0);
        chk("t2_inc3_id", rid3, 7);

        // round-robin between two always-valid channels
        do_reset();
        rsp_ready = 1'b1;
        acc_q.delete();
        rsp_q.delete();
        id0 = 10;
        id1 = 20;
        set_req(0, id0, 0, 0);
        set_req(1, id1, 0, 0);
        nacc = 0;
        for (int i = 0; i < 20 && nacc < 4; i++) begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock);
            #1;
            if (acc[0]) begin id0++; set_req(0, id0, 0, 0); end
            if (acc[1]) begin id1++; set_req(1, id1, 0, 0); end
            nacc += int'(acc[0]) + int'(acc[1]);
        end
        req_valid = '0;
        repeat (6) @(posedge clock);
        #1;
        chk("t3_nacc", acc_q.size(), 4);
        chk("t3_nrsp", rsp_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_acc_ch", (acc_q.size() > i) ? acc_q[i].ch : -1, exp_ch[i]);
            chk("t3_acc_id", (acc_q.size() > i) ? acc_q[i].id : -1, exp_id[i]);
            chk("t3_rsp_ch", (rsp_q.size() > i) ? rsp_q[i].ch : -1, exp_ch[i]);
            chk("t3_rsp_id", (rsp_q.size() > i) ? rsp_q[i].id : -1, exp_id[i]);
        end

        // back-pressure: DEPTH+1 in flight, then drain in order
        do_reset();
        acc_q.delete();
        rsp_q.delete();
        nacc = 0;
        for (int i = 0; i < 7; i++) begin
            send(0, i, 0, i, 10, ok);
            if (!ok) break;
            nacc++;
        end
        chk("t4_accepted", nacc, 5);
        chk("t4_stuck", req_ready, 0);
        chk("t4_hold_id", rsp_id, 0);
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        send(0, 5, 0, 5, 20, ok);
        chk("t4_acc5", ok, 1);
        send(0, 6, 0, 6, 20, ok);
        chk("t4_acc6", ok, 1);
        for (int i = 0; i < 40 && rsp_q.size() < 7; i++) @(posedge clock);
        #1;
        chk("t4_nrsp", rsp_q.size(), 7);
        for (int i = 0; i < 7; i++)
            chk("t4_order", (rsp_q.size() > i) ? rsp_q[i].id : -1, i);

        // introspection and unknown method
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            do_call(0, i, 0, 100, o_ch, o_id, o_d, o_e);
        do_call(1, 30, 2, 0, o_ch, o_id, o_d, o_e);
        chk("t5_m2_data", o_d, 3);
        chk("t5_m2_ch", o_ch, 1);
        chk("t5_m2_err", o_e, 0);
        do_call(0, 9, 3, 123, o_ch, o_id, o_d, o_e);
        chk("t5_m3_err", o_e, 1);
        chk("t5_m3_data", o_d, 0);
        chk("t5_m3_id", o_id, 9);
        chk("t5_calls_done", calls_done, 5);

        // reset mid-operation drops everything
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, 40 + i, 0, i, 10, ok);
            if (!ok) chk("t6_acc", 0, 1);
        end
        chk("t6_pending", rsp_valid, 1);
        #2;
        reset_n      = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        chk("t6_async_valid", rsp_valid, 0);
        chk("t6_rst_ready", req_ready, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
        rsp_q.delete();
        rsp_ready = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("t6_no_rsp", rsp_q.size(), 0);
        chk("t6_calls_done", calls_done, 0);
        set_req(0, 50, 0, 1);
        set_req(1, 60, 0, 2);
        @(negedge clock);
        chk("t6_first_gnt", req_ready, 2'b01);
        @(posedge clock);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
